// File: rtl/mux_pkg.sv
// Shared types for the N-to-1 scanning capture mux.
// The build option MUX_SCAN_PARITY_EN is handled in the interface and top, not here.
package mux_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_VALID = 1'b1
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_scan_nto1_if.sv
// Channel/handshake bundle for mux_scan_nto1; slave is the mux side, master the feeder.
// Defining MUX_SCAN_PARITY_EN adds the dout_par signal.
interface mux_scan_nto1_if #(
    parameter int N_CH = 16,
    parameter int W    = 1
);
    localparam int SEL_W = $clog2(N_CH);

    logic [N_CH*W-1:0] din;
    logic              en;
    logic              mode;
    logic [SEL_W-1:0]  sel;
    logic              sel_load;
    logic              out_ready;
    logic [W-1:0]      dout;
    logic              dout_valid;
    logic [SEL_W-1:0]  cur_sel;
    logic              sel_err;

`ifdef MUX_SCAN_PARITY_EN
    logic              dout_par;

    modport master (
        output din, en, mode, sel, sel_load, out_ready,
        input  dout, dout_valid, cur_sel, sel_err, dout_par
    );

    modport slave (
        input  din, en, mode, sel, sel_load, out_ready,
        output dout, dout_valid, cur_sel, sel_err, dout_par
    );
`else
    modport master (
        output din, en, mode, sel, sel_load, out_ready,
        input  dout, dout_valid, cur_sel, sel_err
    );

    modport slave (
        input  din, en, mode, sel, sel_load, out_ready,
        output dout, dout_valid, cur_sel, sel_err
    );
`endif

endinterface

// File: rtl/mux_sel_ctrl.sv
// Channel pointer for the scanning mux: manual loads with range check, auto-scan wrap,
// and the one-cycle sel_err pulse for a rejected load.
module mux_sel_ctrl
    import mux_pkg::*;
#(
    parameter int N_CH  = 16,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel,
    input  logic             sel_load,
    input  logic             capture,
    output logic [SEL_W-1:0] cur_sel,
    output logic             sel_err
);

    localparam logic [SEL_W:0]   LIMIT = (SEL_W+1)'(N_CH);
    localparam logic [SEL_W-1:0] LAST  = SEL_W'(N_CH - 1);

    logic             sel_ok;
    logic [SEL_W-1:0] sel_nxt;
    logic             err_nxt;

    // A load request always wins over the scan step; a rejected load freezes the pointer.
    always_comb begin
        sel_ok  = ({1'b0, sel} < LIMIT);
        sel_nxt = cur_sel;
        err_nxt = 1'b0;
        if (sel_load) begin
            if (sel_ok) begin
                sel_nxt = sel;
            end else begin
                err_nxt = 1'b1;
            end
        end else if (capture) begin
            case (mode)
                MODE_SCAN:   sel_nxt = (cur_sel == LAST) ? '0 : cur_sel + SEL_W'(1);
                MODE_MANUAL: sel_nxt = cur_sel;
                default:     sel_nxt = cur_sel;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_sel <= '0;
            sel_err <= 1'b0;
        end else begin
            cur_sel <= sel_nxt;
            sel_err <= err_nxt;
        end
    end

endmodule

// File: rtl/mux_scan_nto1.sv
// N-to-1 registered capture mux with valid/ready output handshake and optional auto-scan.
// Defining MUX_SCAN_PARITY_EN adds a registered even-parity bit alongside dout.
module mux_scan_nto1
    import mux_pkg::*;
#(
    parameter int N_CH = 16,
    parameter int W    = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    mux_scan_nto1_if.slave bus
);

    localparam int SEL_W = $clog2(N_CH);

    state_t           state;
    state_t           state_nxt;
    logic             capture;
    logic             valid;
    logic [W-1:0]     chan_data;
    logic [SEL_W-1:0] cur_sel;

    always_comb begin
        chan_data = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (cur_sel == SEL_W'(k)) begin
                chan_data = bus.din[k*W +: W];
            end
        end
    end

    // A held sample only leaves VALID when downstream takes it; out_ready is ignored in IDLE.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        valid     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.en) begin
                    capture   = 1'b1;
                    state_nxt = ST_VALID;
                end
            end
            ST_VALID: begin
                valid = 1'b1;
                if (bus.out_ready) begin
                    if (bus.en) begin
                        capture = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.dout <= '0;
        end else if (capture) begin
            bus.dout <= chan_data;
        end
    end

`ifdef MUX_SCAN_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.dout_par <= 1'b0;
        end else if (capture) begin
            bus.dout_par <= ^chan_data;
        end
    end
`endif

    mux_sel_ctrl #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_sel_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (bus.mode),
        .sel      (bus.sel),
        .sel_load (bus.sel_load),
        .capture  (capture),
        .cur_sel  (cur_sel),
        .sel_err  (bus.sel_err)
    );

    assign bus.dout_valid = valid;
    assign bus.cur_sel    = cur_sel;

endmodule
